// File: rtl/shift_pkg.sv
// Shared types for the sequential shift unit.
// Build with SHIFT_UNIT_ROTATE_EN defined to turn op 2'b11 into rotate-right.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } shift_state_t;

endpackage

// File: rtl/shift_stage.sv
// One logarithmic shift stage: shifts data by 2^k_i for the given op.
// Rotate path exists only when SHIFT_UNIT_ROTATE_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter  int N = 32,
    localparam int L = $clog2(N)
) (
    input  logic [N-1:0] data_i,
    input  shift_op_t    op_i,
    input  logic [L-1:0] k_i,
    output logic [N-1:0] data_o
);

    logic [L-1:0] amt;

    assign amt = L'(1) << k_i;

`ifdef SHIFT_UNIT_ROTATE_EN
    logic [2*N-1:0] rot;

    assign rot = {data_i, data_i} >> amt;
`endif

    always_comb begin
        data_o = data_i;
        unique case (op_i)
            SHIFT_SLL: data_o = data_i << amt;
            SHIFT_SRL: data_o = data_i >> amt;
            SHIFT_SRA: data_o = $unsigned($signed(data_i) >>> amt);
`ifdef SHIFT_UNIT_ROTATE_EN
            SHIFT_ROR: data_o = rot[N-1:0];
`else
            SHIFT_ROR: data_o = data_i;
`endif
            default:   data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle handshaked shifter: one shared stage applied for L cycles.
// Optional rotate (op 2'b11) is enabled by defining SHIFT_UNIT_ROTATE_EN.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter  int N = 32,
    localparam int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [L-1:0] in_shamt,
    input  shift_op_t    in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    shift_state_t state_q;
    logic [N-1:0] data_q;
    logic [N-1:0] data_d;
    logic [N-1:0] stage_data;
    logic [L-1:0] shamt_q;
    logic [L-1:0] cnt_q;
    shift_op_t    op_q;
    logic         in_ready_q;
    logic         out_valid_q;

    shift_stage #(.N(N)) u_stage (
        .data_i (data_q),
        .op_i   (op_q),
        .k_i    (cnt_q),
        .data_o (stage_data)
    );

    // shamt_q shifts right each BUSY cycle, so bit 0 is always bit k
    assign data_d = shamt_q[0] ? stage_data : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            shamt_q     <= '0;
            op_q        <= SHIFT_SLL;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        shamt_q    <= in_shamt;
                        op_q       <= in_op;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    data_q  <= data_d;
                    shamt_q <= shamt_q >> 1;
                    cnt_q   <= cnt_q + L'(1);
                    if (cnt_q == L'(L - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed and random self-checking bench for shift_unit_seq.
// Define SHIFT_UNIT_ROTATE_EN for both RTL and bench to cover ROR.
module tb_shift_unit_seq;
    import shift_pkg::*;

    localparam int N = 32;
    localparam int L = 5;

    typedef struct {
        shift_op_t   op;
        logic [31:0] data;
        logic [4:0]  sh;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    shift_op_t   in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;

    shift_unit_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input shift_op_t op,
                                          input logic [31:0] d,
                                          input logic [4:0] s);
        logic [31:0] r;
        case (op)
            SHIFT_SLL: r = d << s;
            SHIFT_SRL: r = d >> s;
            SHIFT_SRA: r = $unsigned($signed(d) >>> s);
`ifdef SHIFT_UNIT_ROTATE_EN
            default:   r = (d >> s) | (d << (6'd32 - {1'b0, s}));
`else
            default:   r = d;
`endif
        endcase
        return r;
    endfunction

    // Accept one request, measure latency, hold off for stall cycles, drain.
    task automatic run_req(input shift_op_t op, input logic [31:0] d,
                           input logic [4:0] sh, input logic [31:0] exp,
                           input int stall, input string name);
        int w;
        int lat;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_op    = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = 5'($urandom);
        in_op    = shift_op_t'(2'($urandom));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(L));
        check({name, " data"}, out_data, exp);
        repeat (stall) begin
            @(posedge clk);
            #1;
            check({name, " stall valid"}, {31'b0, out_valid}, 32'd1);
            check({name, " stall data"}, out_data, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " drain valid"}, {31'b0, out_valid}, 32'd0);
        check({name, " drain ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{SHIFT_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll31"});
        vecs.push_back('{SHIFT_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, "sra31"});
        vecs.push_back('{SHIFT_SRA, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF, "sra4pos"});
        vecs.push_back('{SHIFT_SRA, 32'hF000_0000, 5'd4,  32'hFF00_0000, "sra4neg"});
        vecs.push_back('{SHIFT_SRL, 32'hF000_0000, 5'd4,  32'h0F00_0000, "srl4"});
        vecs.push_back('{SHIFT_SLL, 32'h1234_5678, 5'd4,  32'h2345_6780, "sll4"});
        vecs.push_back('{SHIFT_SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sll0"});
        vecs.push_back('{SHIFT_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "srl0"});
        vecs.push_back('{SHIFT_SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "sra0"});
`ifdef SHIFT_UNIT_ROTATE_EN
        vecs.push_back('{SHIFT_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, "ror1"});
        vecs.push_back('{SHIFT_ROR, 32'h1234_5678, 5'd7,  32'hF024_68AC, "ror7"});
`else
        vecs.push_back('{SHIFT_ROR, 32'h1234_5678, 5'd7,  32'h1234_5678, "pass7"});
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = SHIFT_SLL;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", {31'b0, in_ready}, 32'd1);
        check("rst out_valid", {31'b0, out_valid}, 32'd0);
        check("rst out_data", out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_req(vecs[i].op, vecs[i].data, vecs[i].sh, vecs[i].exp,
                    0, vecs[i].name);

        // Backpressure: stalled DONE ignores new requests
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hF000_0000;
        in_shamt = 5'd4;
        in_op    = SHIFT_SRL;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (L) @(posedge clk);
        #1;
        check("bp valid", {31'b0, out_valid}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h5555_AAAA;
            in_shamt = 5'd3;
            in_op    = SHIFT_SLL;
            @(posedge clk);
            #1;
            check("bp data", out_data, 32'h0F00_0000);
            check("bp in_ready", {31'b0, in_ready}, 32'd0);
            check("bp hold valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp release ready", {31'b0, in_ready}, 32'd1);
        check("bp release valid", {31'b0, out_valid}, 32'd0);
        repeat (L + 2) @(posedge clk);
        #1;
        check("bp no ghost", {31'b0, out_valid}, 32'd0);
        check("bp idle ready", {31'b0, in_ready}, 32'd1);

        // Reset two edges into BUSY
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hCAFE_F00D;
        in_shamt = 5'd9;
        in_op    = SHIFT_SLL;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid rst valid", {31'b0, out_valid}, 32'd0);
        check("mid rst ready", {31'b0, in_ready}, 32'd1);
        check("mid rst data", out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (L + 1) @(posedge clk);
        #1;
        check("post rst no valid", {31'b0, out_valid}, 32'd0);
        run_req(SHIFT_SRA, 32'h8000_0010, 5'd4, 32'hF800_0001, 1, "post rst");

        for (int i = 0; i < 1000; i++) begin
            shift_op_t   op;
            logic [31:0] d;
            logic [4:0]  s;
            op = shift_op_t'(2'($urandom));
            d  = $urandom;
            s  = 5'($urandom);
            run_req(op, d, s, model(op, d, s), int'($urandom_range(0, 3)),
                    "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
